mac_t_queue_writer: RTL

System-side enqueue engine that feeds the GMII/MII transmit MAC. It accepts byte-wide frames from the switch fabric, which carry no FCS. It writes each frame into either the normal queue (data_fifo/ptr_fifo) or the time-triggered queue (tdata_fifo/tptr_fifo). After the last data byte it writes a 16-bit descriptor whose bits [10:0] hold the frame length. Short frames are zero-padded to the Ethernet minimum, and oversize frames are truncated.

---
 rtl/mac_t_queue_writer_pkg.sv | 28 ++
 rtl/mac_t_stat_cnt.sv | 19 +
 rtl/mac_t_queue_writer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mac_t_queue_writer_pkg.sv
// Shared definitions for the MAC transmit queue writer: FSM encodings,
// frame length defaults and descriptor layout.
package mac_t_queue_writer_pkg;

   typedef enum logic [5:0] {
      ST_IDLE  = 6'd1,
      ST_ADMIT = 6'd2,
      ST_DATA  = 6'd4,
      ST_DROP  = 6'd8,
      ST_PAD   = 6'd16,
      ST_PTR   = 6'd32
   } state_t;

   localparam int MIN_LEN_DEF = 60;
   localparam int MAX_LEN_DEF = 1514;
   localparam int LEN_MSB     = 10;
   localparam int TRUNC_BIT   = 15;

   // Descriptor: [15] truncated, [14:11] zero, [10:0] stored length
   function automatic logic [15:0] mk_desc(input logic trunc, input logic [LEN_MSB:0] len);
      logic [15:0] d;
      d = '0;
      d[TRUNC_BIT]   = trunc;
      d[LEN_MSB:0]   = len;
      return d;
   endfunction

endpackage

// File: rtl/mac_t_stat_cnt.sv
// 16-bit wrapping event counter used for the writer statistics.
module mac_t_stat_cnt (
   input  logic        sys_clk,
   input  logic        rstn_sys,
   input  logic        i_inc,
   output logic [15:0] o_cnt
);

   logic [15:0] r_cnt;

   // Count one per asserted cycle; rolls over from FFFF to 0
   always_ff @(posedge sys_clk or negedge rstn_sys) begin
      if (!rstn_sys) r_cnt <= '0;
      else if (i_inc) r_cnt <= r_cnt + 16'd1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mac_t_queue_writer.sv
// Enqueue engine: writes fabric frames into the normal or time-triggered
// transmit queue, pads short frames, truncates long ones, then writes a
// length descriptor after the last data byte.
module mac_t_queue_writer
   import mac_t_queue_writer_pkg::*;
#(
   parameter int MIN_LEN = MIN_LEN_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int FREE_W  = 12
) (
   input  logic              sys_clk,
   input  logic              rstn_sys,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic              in_tte,
   output logic              data_fifo_wr,
   output logic [7:0]        data_fifo_dout,
   input  logic [FREE_W-1:0] data_fifo_free,
   output logic              ptr_fifo_wr,
   output logic [15:0]       ptr_fifo_dout,
   input  logic              ptr_fifo_full,
   output logic              tdata_fifo_wr,
   output logic [7:0]        tdata_fifo_dout,
   input  logic [FREE_W-1:0] tdata_fifo_free,
   output logic              tptr_fifo_wr,
   output logic [15:0]       tptr_fifo_dout,
   input  logic              tptr_fifo_full,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       trunc_cnt,
   output logic [15:0]       stray_cnt
);

   localparam logic [LEN_MSB:0] MIN_L = (LEN_MSB+1)'(MIN_LEN);
   localparam logic [LEN_MSB:0] MAX_L = (LEN_MSB+1)'(MAX_LEN);
   localparam logic [FREE_W-1:0] SPACE_TH = FREE_W'(MAX_LEN);

   state_t           r_state, w_state_nxt;
   logic [LEN_MSB:0] r_len, w_len_nxt, w_len_inc;
   logic             r_sel, w_sel_nxt;
   logic             r_trunc, w_trunc_nxt;
   logic             w_ready, w_push, w_ptr_push, w_stray, w_space_ok;
   logic [7:0]       w_push_byte;

   logic             r_data_wr, r_tdata_wr, r_ptr_wr, r_tptr_wr;
   logic [7:0]       r_data_dout, r_tdata_dout;
   logic [15:0]      r_ptr_dout, r_tptr_dout;

   assign w_len_inc = r_len + 1'b1;

   // Admission only when a worst-case frame fits and a descriptor slot exists
   assign w_space_ok = r_sel ? ((tdata_fifo_free >= SPACE_TH) && !tptr_fifo_full)
                             : ((data_fifo_free  >= SPACE_TH) && !ptr_fifo_full);

   // FSM state and per-frame context registers
   always_ff @(posedge sys_clk or negedge rstn_sys) begin
      if (!rstn_sys) begin
         r_state <= ST_IDLE;
         r_len   <= '0;
         r_sel   <= 1'b0;
         r_trunc <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_len   <= w_len_nxt;
         r_sel   <= w_sel_nxt;
         r_trunc <= w_trunc_nxt;
      end
   end

   // Next-state, handshake and write-request decode
   always_comb begin
      w_state_nxt = r_state;
      w_len_nxt   = r_len;
      w_sel_nxt   = r_sel;
      w_trunc_nxt = r_trunc;
      w_ready     = 1'b0;
      w_push      = 1'b0;
      w_push_byte = 8'h00;
      w_ptr_push  = 1'b0;
      w_stray     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // sop is held off so it is consumed in DATA, not here
            w_ready = !in_sop;
            if (in_valid) begin
               if (in_sop) begin
                  w_sel_nxt   = in_tte;
                  w_len_nxt   = '0;
                  w_trunc_nxt = 1'b0;
                  w_state_nxt = ST_ADMIT;
               end else begin
                  w_stray = 1'b1;
               end
            end
         end
         ST_ADMIT: begin
            if (w_space_ok) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            w_ready = 1'b1;
            if (in_valid) begin
               w_push      = 1'b1;
               w_push_byte = in_data;
               w_len_nxt   = w_len_inc;
               if (in_eop) begin
                  w_state_nxt = (w_len_inc < MIN_L) ? ST_PAD : ST_PTR;
               end else if (w_len_inc == MAX_L) begin
                  w_trunc_nxt = 1'b1;
                  w_state_nxt = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            w_ready = 1'b1;
            if (in_valid && in_eop) w_state_nxt = ST_PTR;
         end
         ST_PAD: begin
            w_push    = 1'b1;
            w_len_nxt = w_len_inc;
            if (w_len_inc == MIN_L) w_state_nxt = ST_PTR;
         end
         ST_PTR: begin
            w_ptr_push  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Keep the fabric stalled while reset is held
   assign in_ready = rstn_sys & w_ready;

   // Registered FIFO write ports; the unselected queue is held at zero
   always_ff @(posedge sys_clk or negedge rstn_sys) begin
      if (!rstn_sys) begin
         r_data_wr    <= 1'b0;
         r_data_dout  <= '0;
         r_tdata_wr   <= 1'b0;
         r_tdata_dout <= '0;
         r_ptr_wr     <= 1'b0;
         r_ptr_dout   <= '0;
         r_tptr_wr    <= 1'b0;
         r_tptr_dout  <= '0;
      end else begin
         r_data_wr    <= w_push & !r_sel;
         r_data_dout  <= (w_push & !r_sel) ? w_push_byte : 8'h00;
         r_tdata_wr   <= w_push & r_sel;
         r_tdata_dout <= (w_push & r_sel) ? w_push_byte : 8'h00;
         r_ptr_wr     <= w_ptr_push & !r_sel;
         r_ptr_dout   <= (w_ptr_push & !r_sel) ? mk_desc(r_trunc, r_len) : 16'h0000;
         r_tptr_wr    <= w_ptr_push & r_sel;
         r_tptr_dout  <= (w_ptr_push & r_sel) ? mk_desc(r_trunc, r_len) : 16'h0000;
      end
   end

   assign data_fifo_wr    = r_data_wr;
   assign data_fifo_dout  = r_data_dout;
   assign tdata_fifo_wr   = r_tdata_wr;
   assign tdata_fifo_dout = r_tdata_dout;
   assign ptr_fifo_wr     = r_ptr_wr;
   assign ptr_fifo_dout   = r_ptr_dout;
   assign tptr_fifo_wr    = r_tptr_wr;
   assign tptr_fifo_dout  = r_tptr_dout;

   mac_t_stat_cnt u_frame_cnt (
      .sys_clk (sys_clk), .rstn_sys (rstn_sys),
      .i_inc   (w_ptr_push), .o_cnt (frame_cnt)
   );

   mac_t_stat_cnt u_trunc_cnt (
      .sys_clk (sys_clk), .rstn_sys (rstn_sys),
      .i_inc   (w_ptr_push & r_trunc), .o_cnt (trunc_cnt)
   );

   mac_t_stat_cnt u_stray_cnt (
      .sys_clk (sys_clk), .rstn_sys (rstn_sys),
      .i_inc   (w_stray), .o_cnt (stray_cnt)
   );

endmodule
